// File: rtl/decrypt_pkg.sv
// decrypt_pkg: shared FSM states, mode codes and mask pattern for the decrypt engine.
// Revision 1.0
`default_nettype none
package decrypt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    ROUND  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic MODE_SUB = 1'b0;
  localparam logic MODE_XOR = 1'b1;

  // Bit s is the inversion applied to key segment s (mod 5): K,~K,~K,K,~K
  localparam logic [4:0] INV_PATTERN = 5'b10110;

  function automatic int frame_w(input int hdr_w, input int key_w, input int data_w);
    return hdr_w + key_w + data_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mask_expand.sv
// mask_expand: combinational key -> DATA_W mask, key tiled with per-segment inversion.
// Revision 1.0
`default_nettype none
module mask_expand
  import decrypt_pkg::*;
#(
  parameter int KEY_W  = 11,
  parameter int DATA_W = 61
) (
  input  logic [KEY_W-1:0]  i_key,
  output logic [DATA_W-1:0] o_mask
);

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    assign o_mask[i] = i_key[i % KEY_W] ^ INV_PATTERN[(i / KEY_W) % 5];
  end

endmodule
`default_nettype wire

// File: rtl/decrypt_function_param.sv
// decrypt_function_param: framed multi-round decryption engine with valid/ready on both sides.
// Revision 1.0
`default_nettype none
module decrypt_function_param
  import decrypt_pkg::*;
#(
  parameter int HDR_W  = 6,
  parameter int KEY_W  = 11,
  parameter int DATA_W = 61,
  parameter int ROUNDS = 1
) (
  input  logic                                       Clk,
  input  logic                                       Reset,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [frame_w(HDR_W, KEY_W, DATA_W)-1:0]   in_frame,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [DATA_W-1:0]                          out_data,
  output logic                                       busy
);

  localparam int RND_W = $clog2(ROUNDS + 1);
  localparam logic [RND_W-1:0] c_LAST_RND = RND_W'(ROUNDS - 1);

  state_t              r_state, w_next;
  logic [KEY_W-1:0]    r_key, w_key_rot, w_mask_key;
  logic [DATA_W-1:0]   r_data, r_mask, w_mask;
  logic                r_mode;
  logic [RND_W-1:0]    r_rnd;
  logic                w_accept;
  logic                w_unused_hdr;

  assign w_key_rot    = {r_key[KEY_W-2:0], r_key[KEY_W-1]};
  // In ROUND the next mask must come from the key being rotated this cycle
  assign w_mask_key   = (r_state == ROUND) ? w_key_rot : r_key;
  assign w_accept     = in_valid & in_ready;
  assign out_data     = r_data;
  assign w_unused_hdr = &{1'b0, in_frame[HDR_W-1:1]};

  mask_expand #(.KEY_W(KEY_W), .DATA_W(DATA_W)) u_mask_expand (
    .i_key  (w_mask_key),
    .o_mask (w_mask)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) w_next = EXPAND;
      end
      EXPAND: w_next = ROUND;
      ROUND:  if (r_rnd == c_LAST_RND) w_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready = 1'b1;
          w_next   = in_valid ? EXPAND : IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_key  <= '0;
      r_data <= '0;
      r_mask <= '0;
      r_mode <= MODE_SUB;
      r_rnd  <= '0;
    end else if (w_accept) begin
      r_data <= in_frame[HDR_W+KEY_W +: DATA_W];
      r_key  <= in_frame[HDR_W +: KEY_W];
      r_mode <= in_frame[0];
    end else if (r_state == EXPAND) begin
      r_mask <= w_mask;
      r_rnd  <= '0;
    end else if (r_state == ROUND) begin
      r_data <= (r_mode == MODE_XOR) ? (r_data ^ r_mask) : (r_data - r_mask);
      r_key  <= w_key_rot;
      r_mask <= w_mask;
      r_rnd  <= r_rnd + RND_W'(1);
    end
  end

endmodule
`default_nettype wire
